// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg: shared types, size codes and byte-extension helper. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_stage_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam logic SZ_BYTE = 1'b0;
  localparam logic SZ_WORD = 1'b1;

  // Wide enough for any legal DATA_W; callers size-cast the result down.
  localparam int EXT_W = 64;

  function automatic logic [EXT_W-1:0] extend_byte(input logic [7:0] b, input logic sgn);
    return {{(EXT_W-8){sgn & b[7]}}, b};
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_ram.sv
// ---------------------------------------------------------------------------
// mem_stage_ram: single-port read-first RAM, byte enables, registered read. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_stage_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int AW     = 10
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       addr,
  input  logic [DATA_W/8-1:0] be,
  input  logic [DATA_W-1:0]   wdata,
  output logic [DATA_W-1:0]   rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    rdata <= mem[addr];
    for (int i = 0; i < NB; i++) begin
      if (we && be[i]) begin
        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage_unit.sv
// ---------------------------------------------------------------------------
// mem_stage_unit: data-memory pipeline stage with clear FSM and checked access. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_stage_unit
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              in_mem_en,
  input  logic              in_we,
  input  logic              in_size,
  input  logic              in_signed,
  input  logic              in_sel_mem,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err
);

  localparam int NB     = DATA_W / 8;
  localparam int LANE_W = $clog2(NB);
  localparam int IDX_W  = ADDR_W - LANE_W;
  localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t              state;
  logic [RAM_AW-1:0]   clr_ptr;

  logic                accept;
  logic [IDX_W-1:0]    widx;
  logic [LANE_W-1:0]   lane;
  logic                req_err;
  logic [NB-1:0]       lane_be;

  logic                ram_we;
  logic [RAM_AW-1:0]   ram_addr;
  logic [NB-1:0]       ram_be;
  logic [DATA_W-1:0]   ram_wdata;
  logic [DATA_W-1:0]   ram_rdata;

  logic                s1_valid, s1_err, s1_mem_en, s1_sel_mem, s1_size, s1_signed;
  logic [LANE_W-1:0]   s1_lane;
  logic [DATA_W-1:0]   s1_pass;
  logic [7:0]          sel_byte;
  logic [DATA_W-1:0]   result;

  assign in_ready = (state == RUN);
  assign accept   = in_valid && in_ready;
  assign widx     = in_addr[ADDR_W-1:LANE_W];
  assign lane     = in_addr[LANE_W-1:0];
  assign req_err  = in_mem_en &&
                    (({1'b0, widx} >= (IDX_W+1)'(DEPTH)) ||
                     (in_size == SZ_WORD && lane != '0));

  always_comb begin
    lane_be = '0;
    for (int i = 0; i < NB; i++) begin
      lane_be[i] = (in_size == SZ_WORD) || (lane == LANE_W'(i));
    end
  end

  // The clear sequence owns the single RAM port until the FSM reaches RUN.
  always_comb begin
    if (state == CLEAR) begin
      ram_we    = 1'b1;
      ram_addr  = clr_ptr;
      ram_be    = '1;
      ram_wdata = '0;
    end else begin
      ram_we    = accept && in_mem_en && in_we && !req_err;
      ram_addr  = widx[RAM_AW-1:0];
      ram_be    = lane_be;
      ram_wdata = (in_size == SZ_WORD) ? in_wdata : {NB{in_wdata[7:0]}};
    end
  end

  mem_stage_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAM_AW)
  ) u_ram (
    .clk    (clk),
    .we     (ram_we),
    .addr   (ram_addr),
    .be     (ram_be),
    .wdata  (ram_wdata),
    .rdata  (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else if (state == CLEAR) begin
      clr_ptr <= clr_ptr + RAM_AW'(1);
      if (clr_ptr == RAM_AW'(DEPTH - 1)) begin
        state <= RUN;
      end
    end
  end

  // Request attributes travel alongside the one-cycle RAM read.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_err     <= 1'b0;
      s1_mem_en  <= 1'b0;
      s1_sel_mem <= 1'b0;
      s1_size    <= SZ_BYTE;
      s1_signed  <= 1'b0;
      s1_lane    <= '0;
      s1_pass    <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_err     <= req_err;
        s1_mem_en  <= in_mem_en;
        s1_sel_mem <= in_sel_mem;
        s1_size    <= in_size;
        s1_signed  <= in_signed;
        s1_lane    <= lane;
        s1_pass    <= DATA_W'(in_addr);
      end
    end
  end

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NB; i++) begin
      if (s1_lane == LANE_W'(i)) begin
        sel_byte = ram_rdata[i*8 +: 8];
      end
    end
  end

  always_comb begin
    if (s1_err) begin
      result = '0;
    end else if (s1_mem_en && s1_sel_mem) begin
      result = (s1_size == SZ_WORD) ? ram_rdata : DATA_W'(extend_byte(sel_byte, s1_signed));
    end else begin
      result = s1_pass;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      out_err   <= s1_valid && s1_err;
      if (s1_valid) begin
        out_data <= result;
      end
    end
  end

endmodule

`default_nettype wire
